// File: rtl/magnetron_control.sv
// magnetron_control: registered magnetron enable latched by start, dropped by stop/clear/door/timer.
// Define MAGNETRON_DEBOUNCE_EN to add counter filters on the start/stop/clear buttons.
module magnetron_control #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic startn,
  input  logic stopn,
  input  logic clearn,
  input  logic door_closed,
  input  logic timer_done,
  output logic Q
);
  // sync bit order: {startn, stopn, clearn, door_closed, timer_done}
  localparam logic [4:0] IDLE = 5'b11100;
  typedef enum logic {OFF, ON} state_t;
  state_t state, state_nx;
  logic [4:0] sync [SYNC_STAGES];
  logic [4:0] s;
  logic [2:0] btn;
  logic kill, go;
  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1) begin : g_bad
      $error("magnetron_control: illegal SYNC_STAGES or DEBOUNCE_CYCLES");
    end
  endgenerate
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= IDLE;
    end else begin
      sync[0] <= {startn, stopn, clearn, door_closed, timer_done};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  assign s = sync[SYNC_STAGES-1];
`ifdef MAGNETRON_DEBOUNCE_EN
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [CW-1:0] cnt [3];
  // a filtered button follows its raw value only after DEBOUNCE_CYCLES disagreeing clocks
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      btn <= 3'b111;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (s[i+2] == btn[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          btn[i] <= s[i+2];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + CW'(1);
    end
`else
  assign btn = s[4:2];
`endif
  assign kill = ~btn[1] | ~btn[0] | ~s[1] | s[0];
  assign go   = ~btn[2] & ~kill;
  always_comb state_nx = (state == OFF) ? (go ? ON : OFF) : (kill ? OFF : ON);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= OFF;
    else state <= state_nx;
  assign Q = (state == ON);
endmodule

// File: tb/tb_magnetron_control.sv
// tb_magnetron_control: directed checks of the magnetron enable against a latency-based model.
module tb_magnetron_control;
  localparam int SS = 2;
  localparam int D  = 4;
  logic clk = 0, resetn = 0, startn = 1, stopn = 1, clearn = 1, door_closed = 0, timer_done = 0;
  logic Q;
  int total = 0, bad = 0;
  magnetron_control #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn), .clearn(clearn),
    .door_closed(door_closed), .timer_done(timer_done), .Q(Q));
  always #5 clk = ~clk;
  // Model: the FSM sees the raw input sampled SS edges earlier; h[0] is the newest sample.
  logic [4:0] h [0:15];
  logic [2:0] filt;
  logic mq;
  always @(posedge clk or negedge resetn) begin
    logic [4:0] v;
    logic [2:0] b;
    logic kill, go;
    if (!resetn) begin
      for (int i = 0; i < 16; i++) h[i] <= 5'b11100;
      filt <= 3'b111;
      mq <= 1'b0;
    end else begin
      for (int i = 1; i < 16; i++) h[i] <= h[i-1];
      h[0] <= {startn, stopn, clearn, door_closed, timer_done};
      v = h[SS-1];
`ifdef MAGNETRON_DEBOUNCE_EN
      b = filt;
      for (int k = 0; k < 3; k++) begin
        logic all_diff;
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) if (h[SS-1+j][k+2] == filt[k]) all_diff = 1'b0;
        if (all_diff) filt[k] <= ~filt[k];
      end
`else
      b = v[4:2];
`endif
      kill = !b[1] || !b[0] || !v[1] || v[0];
      go = !b[2] && !kill;
      mq <= mq ? !kill : go;
    end
  end
  always @(negedge clk) begin
    total++;
    if (Q !== mq) begin
      bad++;
      $display("FAIL model t=%0t Q=%b expected=%b", $time, Q, mq);
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string nm, input logic exp);
    total++;
    if (Q !== exp) begin
      bad++;
      $display("FAIL %s t=%0t Q=%b expected=%b", nm, $time, Q, exp);
    end
  endtask
  initial begin
    startn = 0; door_closed = 1;
    #3 chk("reset_async", 1'b0);
    cyc(2);
    startn = 1; resetn = 1;
    cyc(5); chk("reset_release", 1'b0);
`ifdef MAGNETRON_DEBOUNCE_EN
    startn = 0; cyc(3); startn = 1;
    cyc(10); chk("db_short_press", 1'b0);
    startn = 0; cyc(6); chk("db_before_on", 1'b0);
    cyc(1); chk("db_on_L4", 1'b1);
    startn = 1; cyc(10); chk("db_hold", 1'b1);
    door_closed = 0; cyc(2); chk("db_door_pre", 1'b1);
    cyc(1); chk("db_door_fast_off", 1'b0);
    door_closed = 1; cyc(10); chk("db_door_reclose", 1'b0);
`else
    startn = 0; cyc(2); chk("start_pre", 1'b0);
    cyc(1); chk("start_on_L", 1'b1);
    startn = 1; cyc(5); chk("start_release_hold", 1'b1);
    stopn = 0; cyc(2); chk("stop_pre", 1'b1);
    cyc(1); chk("stop_off_L", 1'b0);
    cyc(7); stopn = 1; cyc(5); chk("stop_release", 1'b0);
    startn = 0; cyc(3); chk("restart", 1'b1);
    startn = 1; cyc(3);
    door_closed = 0; cyc(3); chk("door_open_off", 1'b0);
    startn = 0; cyc(5); chk("start_door_open", 1'b0);
    door_closed = 1; cyc(3); chk("door_reclose_level_start", 1'b1);
    startn = 1; cyc(3);
    timer_done = 1; cyc(3); chk("timer_off", 1'b0);
    timer_done = 0; cyc(5); chk("timer_clear", 1'b0);
    startn = 0; stopn = 0; cyc(5); chk("start_stop_off", 1'b0);
    startn = 1; stopn = 1; cyc(5); chk("start_stop_release", 1'b0);
    startn = 0; cyc(3); chk("on_again", 1'b1);
    stopn = 0; cyc(3); chk("start_stop_while_on", 1'b0);
    startn = 1; stopn = 1; cyc(5);
    startn = 0; cyc(3); chk("on_before_clear", 1'b1);
    startn = 1; clearn = 0; cyc(3); chk("clear_off", 1'b0);
    clearn = 1; cyc(5); chk("clear_release", 1'b0);
    startn = 0; cyc(3); chk("on_before_reset", 1'b1);
    startn = 1;
    #2 resetn = 0;
    #1 chk("reset_midcook", 1'b0);
    @(negedge clk); resetn = 1;
    cyc(5); chk("after_midcook_reset", 1'b0);
`endif
    for (int i = 0; i < 120; i++) begin
      startn      = ($urandom_range(0, 2) != 0);
      stopn       = ($urandom_range(0, 5) != 0);
      clearn      = ($urandom_range(0, 7) != 0);
      door_closed = ($urandom_range(0, 5) != 0);
      timer_done  = ($urandom_range(0, 7) == 0);
      cyc($urandom_range(1, 8));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
